// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core, its sample/result memories and the
// result streamer. Holds the common widths and the streamer FSM encoding so
// that checkers and debug taps can decode the state exposed by the streamer.
package fir_pkg;

  localparam int SAMPLE_W   = 22;   // filtered sample / result memory word
  localparam int COEF_W     = 13;   // coefficient width used by the FIR core
  localparam int MEM_ADDR_W = 8;    // result memory address width
  localparam int MEM_DEPTH  = 256;  // result memory words

  // Result streamer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } streamer_state_e;

endpackage

// File: rtl/fir_result_streamer_if.sv
// Bus bundles used by the FIR result streamer.
//
// fir_mem_rd_if : read port of the result memory.
//   mem_rd_en   master->slave  read strobe
//   mem_addr    master->slave  read address
//   mem_rd_data slave->master  read data, valid a fixed latency after mem_rd_en
//
// fir_stream_if : ordered sample stream.
//   out_valid   master->slave  sample present
//   out_ready   slave->master  downstream accept
//   out_data    master->slave  sample value
//   out_last    master->slave  final sample of the frame
//
// Handshake: a beat transfers on a clock edge where out_valid and out_ready
// are both 1. Once out_valid is raised it stays high, and out_data/out_last
// stay stable, until that beat transfers; out_valid never waits on out_ready.

interface fir_mem_rd_if
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = MEM_ADDR_W
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

interface fir_stream_if
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fir_result_streamer_skid_fifo.sv
// fir_skid_fifo: small synchronous FIFO with an occupancy count.
// The head entry is presented combinationally. There is no overflow or
// underflow protection: the owner must only push when space is guaranteed
// and only pop when not empty. Push and pop in the same cycle are allowed.
//
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset (empties the FIFO)
//   push_i       write push_data_i at the tail
//   push_data_i  data to write
//   pop_i        drop the head entry
//   head_o       current head entry
//   empty_o      FIFO holds no entries
//   count_o      number of entries held
module fir_skid_fifo #(
  parameter int W = 22,
  parameter int D = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic [$clog2(D+1)-1:0] count_o
);

  localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
  localparam int CNT_W = $clog2(D + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(D - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [W-1:0]     mem_q [D];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale words are never visible while empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fir_result_streamer.sv
// fir_result_streamer: reads a frame of filtered samples back from the FIR
// result memory and delivers them in address order as a valid/ready stream.
// Reads are issued only when the skid FIFO is guaranteed to have room for the
// returning word, which hides the memory read latency and sustains one sample
// per cycle while downstream keeps out_ready high.
//
// Ports:
//   clk100       clock
//   reset        synchronous active-low reset; aborts any frame
//   start        one-cycle frame start, honoured only when idle
//   base_addr    first address of the frame (latched on start)
//   num_samples  frame length 0..2^ADDR_W (latched on start)
//   mem          result memory read port (master)
//   strm         output sample stream (master)
//   busy         frame in progress
//   done         one-cycle pulse when the frame has completed
//   dbg_state_o  current FSM state
module fir_result_streamer
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int FIFO_D = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_samples,
  fir_mem_rd_if.master      mem,
  fir_stream_if.master      strm,
  output logic              busy,
  output logic              done,
  output streamer_state_e   dbg_state_o
);

  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int CRED_W = $clog2(FIFO_D + RD_LAT + 1) + 1;
  localparam logic [ADDR_W:0]   N_ONE    = (ADDR_W + 1)'(1);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_D);

  streamer_state_e   state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   delivered_q, delivered_d;
  logic [CRED_W-1:0] inflight_q, inflight_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              rd_en;
  logic              push;
  logic              pop;
  logic              last_beat;
  logic [CRED_W-1:0] credit_used;

  // Word returning from memory this cycle.
  assign push = rd_pipe_q[RD_LAT-1];

  assign strm.out_valid = !fifo_empty;
  assign pop            = strm.out_valid & strm.out_ready;
  assign last_beat      = strm.out_valid & (delivered_q == num_q - N_ONE);
  assign strm.out_last  = last_beat;
  assign strm.out_data  = strm.out_valid ? fifo_head : '0;

  // Slots already claimed: entries held plus reads still in flight. A pop
  // this cycle frees its slot at the same edge the new read is issued, which
  // keeps the stream bubble-free with a FIFO only RD_LAT+1 deep.
  assign credit_used = CRED_W'(fifo_count) + inflight_q - (pop ? CRED_ONE : '0);

  assign rd_en = (state_q == ST_READ) && (issued_q < num_q) && (credit_used < CRED_MAX);

  assign mem.mem_rd_en = rd_en;
  assign mem.mem_addr  = rd_en ? (base_q + issued_q[ADDR_W-1:0]) : '0;

  assign rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(rd_en);

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en && !push)      inflight_d = inflight_q + CRED_ONE;
    else if (!rd_en && push) inflight_d = inflight_q - CRED_ONE;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q + (rd_en ? N_ONE : '0);
    delivered_d = delivered_q + (pop ? N_ONE : '0);
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          num_d       = num_samples;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (num_samples == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (rd_en && (issued_q + N_ONE == num_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave on the final handshake so done follows the last beat directly.
        if (pop && last_beat) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign dbg_state_o = state_q;

  fir_skid_fifo #(
    .W (DATA_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk_i       (clk100),
    .rst_n_i     (reset),
    .push_i      (push),
    .push_data_i (mem.mem_rd_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed bench for fir_result_streamer. A behavioural result memory holds
// word[a] = a + 0x100. Expected addresses and {last,data} words are queued
// when a frame is started and popped as the DUT issues reads / hands off beats.
module tb_fir_result_streamer;
  import fir_pkg::*;

  localparam int DATA_W = 22;
  localparam int ADDR_W = 8;
  localparam int FIFO_D = 2;
  localparam int RD_LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_samples;
  logic              busy;
  logic              done;
  streamer_state_e   dbg_state;

  fir_mem_rd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();
  fir_stream_if #(.DATA_W(DATA_W)) strm_if ();

  fir_result_streamer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FIFO_D (FIFO_D),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk100      (clk100),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_samples (num_samples),
    .mem         (mem_if),
    .strm        (strm_if),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Result memory, one cycle read latency.
  logic [DATA_W-1:0] mem_words [256];
  always @(posedge clk100) begin
    if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem_words[mem_if.mem_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt, issued_cnt, done_cnt;
  int first_valid_cyc, last_hs_cyc, done_cyc;
  bit bp_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [DATA_W:0] prev_word;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observes the cycle at the negedge, i.e. the values the next edge acts on.
  task automatic monitor();
    logic [DATA_W:0] word;
    cyc++;
    word = {strm_if.out_last, strm_if.out_data};
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_if.mem_rd_en) begin
        issued_cnt++;
        checks++;
        assert (exp_addr_q.size() > 0) else begin
          errors++;
          $error("FAIL addr_unexpected observed=%0h expected=none", mem_if.mem_addr);
        end
        if (exp_addr_q.size() > 0) check_eq("mem_addr", 32'(mem_if.mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (prev_stall) begin
        check_eq("stall_valid", 32'(strm_if.out_valid), 32'd1);
        check_eq("stall_word", 32'(word), 32'(prev_word));
      end
      prev_stall = strm_if.out_valid && !strm_if.out_ready;
      prev_word  = word;
      if (strm_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (strm_if.out_valid && strm_if.out_ready) begin
        beat_cnt++;
        last_hs_cyc = cyc;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL beat_unexpected observed=%0h expected=none", word);
        end
        if (exp_q.size() > 0) check_eq("beat_word", 32'(word), 32'(exp_q.pop_front()));
      end
      // Reads issued but not yet delivered may never exceed the FIFO depth.
      check_eq("outstanding_le_depth", 32'((issued_cnt - beat_cnt) <= FIFO_D), 32'd1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (bp_mode) strm_if.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk100);
    monitor();
    @(posedge clk100);
    #1;
  endtask

  task automatic clear_counts();
    beat_cnt = 0; issued_cnt = 0; done_cnt = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
  endtask

  task automatic load_expect(input logic [ADDR_W-1:0] base, input int num);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < num; i++) begin
      a = base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back({1'(i == num - 1), DATA_W'(32'(a) + 32'h100)});
    end
  endtask

  task automatic check_idle_zero(input string pfx);
    check_eq({pfx, "_rd_en"}, 32'(mem_if.mem_rd_en), 32'd0);
    check_eq({pfx, "_addr"}, 32'(mem_if.mem_addr), 32'd0);
    check_eq({pfx, "_valid"}, 32'(strm_if.out_valid), 32'd0);
    check_eq({pfx, "_data"}, 32'(strm_if.out_data), 32'd0);
    check_eq({pfx, "_last"}, 32'(strm_if.out_last), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Runs one frame to completion. stray_beat >= 0 pulses a second start once
  // that many beats have transferred; it must be ignored.
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int num, input int stray_beat);
    int s;
    bit stray_sent;
    stray_sent = 1'b0;
    clear_counts();
    load_expect(base, num);
    base_addr   = base;
    num_samples = (ADDR_W + 1)'(num);
    start       = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    check_eq("busy_after_start", 32'(busy), 32'(num > 0));
    for (int k = 0; k < num * 4 + 20 && done_cnt == 0; k++) begin
      if (stray_beat >= 0 && !stray_sent && beat_cnt == stray_beat) begin
        start       = 1'b1;
        base_addr   = base + 8'd77;
        num_samples = 9'd5;
        stray_sent  = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check_eq("done_seen", 32'(done_cnt), 32'd1);
    tick();
    tick();
    check_eq("done_single_pulse", 32'(done_cnt), 32'd1);
    check_idle_zero("post_frame");
    check_eq("beats", 32'(beat_cnt), 32'(num));
    check_eq("reads", 32'(issued_cnt), 32'(num));
    check_eq("exp_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("exp_addr_left", 32'(exp_addr_q.size()), 32'd0);
    if (num > 0) begin
      // start is sampled at the edge ending tick s; the first beat is
      // visible RD_LAT+1 edges later, in tick s+RD_LAT+2.
      check_eq("first_valid_cyc", 32'(first_valid_cyc), 32'(s + RD_LAT + 2));
      check_eq("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
      if (!bp_mode) check_eq("last_beat_cyc", 32'(last_hs_cyc), 32'(s + num + RD_LAT + 1));
    end else begin
      check_eq("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      check_eq("zero_done_cyc", 32'(done_cyc), 32'(s + 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = DATA_W'(i + 'h100);
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_samples = '0;
    strm_if.out_ready = 1'b1;
    clear_counts();
    repeat (3) tick();
    check_idle_zero("reset");
    reset = 1'b1;
    tick();

    // Basic frame: 0x100..0x1FB, last only on beat 251.
    run_frame(8'd0, 252, -1);

    // Backpressure with random ready.
    bp_mode = 1'b1;
    run_frame(8'd40, 16, -1);
    bp_mode = 1'b0;
    strm_if.out_ready = 1'b1;
    tick();

    // Address wrap 250..255, 0..3.
    run_frame(8'd250, 10, -1);

    // Zero length frame.
    run_frame(8'd7, 0, -1);

    // Full 256-word frame from a non-zero base.
    run_frame(8'd128, 256, -1);

    // Start while busy during beat 3.
    run_frame(8'd20, 12, 2);

    // Reset mid-frame after the 5th beat.
    clear_counts();
    load_expect(8'd60, 20);
    base_addr = 8'd60;
    num_samples = 9'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && beat_cnt < 5; k++) tick();
    check_eq("mid_beats_before_reset", 32'(beat_cnt), 32'd5);
    reset = 1'b0;
    tick();
    check_idle_zero("mid_reset");
    tick();
    tick();
    check_eq("mid_reset_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    reset = 1'b1;
    tick();
    run_frame(8'd60, 20, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
